// File: rtl/wb_merge.sv
// Writeback merge: buffers ALU0/ALU1/MEM results one deep each and retires up to
// two per cycle onto register-file ports D1/D2, oldest on D1.
module wb_merge #(
   parameter  int unsigned FILESIZE = 32,
   parameter  int unsigned REGSIZE  = 32,
   parameter  int unsigned SEQW     = 4,
   localparam int unsigned REGADDR  = $clog2(FILESIZE)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               alu0_valid,
   output logic               alu0_ready,
   input  logic [REGADDR-1:0] alu0_rd,
   input  logic [REGSIZE-1:0] alu0_data,
   input  logic [SEQW-1:0]    alu0_seq,
   input  logic               alu1_valid,
   output logic               alu1_ready,
   input  logic [REGADDR-1:0] alu1_rd,
   input  logic [REGSIZE-1:0] alu1_data,
   input  logic [SEQW-1:0]    alu1_seq,
   input  logic               mem_valid,
   output logic               mem_ready,
   input  logic [REGADDR-1:0] mem_rd,
   input  logic [REGSIZE-1:0] mem_data,
   input  logic [SEQW-1:0]    mem_seq,
   output logic               write1,
   output logic [REGADDR-1:0] writeAddr_D1,
   output logic [REGSIZE-1:0] writeData_D1,
   output logic               write2,
   output logic [REGADDR-1:0] writeAddr_D2,
   output logic [REGSIZE-1:0] writeData_D2,
   output logic [1:0]         retire_cnt
);

   localparam int unsigned NSRC = 3;

   typedef struct packed {
      logic               valid;
      logic [REGADDR-1:0] rd;
      logic [REGSIZE-1:0] data;
      logic [SEQW-1:0]    seq;
   } entry_t;

   entry_t             ent_q [NSRC];
   entry_t             ent_d [NSRC];
   entry_t             src   [NSRC];
   logic               rdy   [NSRC];
   logic               gnt1  [NSRC];
   logic               gnt2  [NSRC];
   logic [1:0]         rank  [NSRC];
   entry_t             sel1;
   entry_t             sel2;

   logic               write1_q, write1_d;
   logic               write2_q, write2_d;
   logic [REGADDR-1:0] addr1_q, addr1_d;
   logic [REGADDR-1:0] addr2_q, addr2_d;
   logic [REGSIZE-1:0] data1_q, data1_d;
   logic [REGSIZE-1:0] data2_q, data2_d;
   logic [1:0]         retire_cnt_q, retire_cnt_d;

   // Wrap-safe age: a is older than b when (a - b) mod 2^SEQW has its MSB set.
   function automatic logic older(input logic [SEQW-1:0] a, input logic [SEQW-1:0] b);
      logic [SEQW-1:0] diff;
      diff = a - b;
      return diff[SEQW-1];
   endfunction

   always_comb begin
      src[0] = '{valid: alu0_valid, rd: alu0_rd, data: alu0_data, seq: alu0_seq};
      src[1] = '{valid: alu1_valid, rd: alu1_rd, data: alu1_data, seq: alu1_seq};
      src[2] = '{valid: mem_valid,  rd: mem_rd,  data: mem_data,  seq: mem_seq};
   end

   // Rank each held entry by how many valid entries are older; rank 0 -> D1, rank 1 -> D2.
   always_comb begin
      sel1 = '0;
      sel2 = '0;
      for (int i = 0; i < NSRC; i++) begin
         rank[i] = 2'd0;
         for (int j = 0; j < NSRC; j++) begin
            if (j != i && ent_q[j].valid && older(ent_q[j].seq, ent_q[i].seq))
               rank[i] = rank[i] + 2'd1;
         end
         gnt1[i] = ent_q[i].valid && (rank[i] == 2'd0);
         gnt2[i] = ent_q[i].valid && (rank[i] == 2'd1);
         if (gnt1[i]) sel1 = ent_q[i];
         if (gnt2[i]) sel2 = ent_q[i];
      end
   end

   // Entry update: granted entries drain, accepted results refill (rd 0 is dropped).
   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         rdy[i]   = !reset && (!ent_q[i].valid || gnt1[i] || gnt2[i]);
         ent_d[i] = ent_q[i];
         if (gnt1[i] || gnt2[i])
            ent_d[i].valid = 1'b0;
         if (src[i].valid && rdy[i] && (src[i].rd != '0))
            ent_d[i] = src[i];
      end
   end

   always_comb begin
      write1_d     = sel1.valid;
      write2_d     = sel2.valid;
      addr1_d      = sel1.valid ? sel1.rd   : addr1_q;
      data1_d      = sel1.valid ? sel1.data : data1_q;
      addr2_d      = sel2.valid ? sel2.rd   : addr2_q;
      data2_d      = sel2.valid ? sel2.data : data2_q;
      retire_cnt_d = {1'b0, sel1.valid} + {1'b0, sel2.valid};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NSRC; i++) ent_q[i] <= '0;
         write1_q     <= 1'b0;
         write2_q     <= 1'b0;
         addr1_q      <= '0;
         addr2_q      <= '0;
         data1_q      <= '0;
         data2_q      <= '0;
         retire_cnt_q <= 2'd0;
      end else begin
         for (int i = 0; i < NSRC; i++) ent_q[i] <= ent_d[i];
         write1_q     <= write1_d;
         write2_q     <= write2_d;
         addr1_q      <= addr1_d;
         addr2_q      <= addr2_d;
         data1_q      <= data1_d;
         data2_q      <= data2_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign alu0_ready   = rdy[0];
   assign alu1_ready   = rdy[1];
   assign mem_ready    = rdy[2];
   assign write1       = write1_q;
   assign write2       = write2_q;
   assign writeAddr_D1 = addr1_q;
   assign writeAddr_D2 = addr2_q;
   assign writeData_D1 = data1_q;
   assign writeData_D2 = data2_q;
   assign retire_cnt   = retire_cnt_q;

endmodule

// File: tb/tb_wb_merge.sv
// Directed bench for wb_merge: ordering, wrap-around age, same-rd, rd0 drop, resets.
module tb_wb_merge;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu0_valid, alu1_valid, mem_valid;
   logic        alu0_ready, alu1_ready, mem_ready;
   logic [4:0]  alu0_rd, alu1_rd, mem_rd;
   logic [31:0] alu0_data, alu1_data, mem_data;
   logic [3:0]  alu0_seq, alu1_seq, mem_seq;
   logic        write1, write2;
   logic [4:0]  writeAddr_D1, writeAddr_D2;
   logic [31:0] writeData_D1, writeData_D2;
   logic [1:0]  retire_cnt;

   logic [31:0] rf [32];
   int          n_cmp = 0;
   int          n_bad = 0;

   wb_merge dut (
      .clk(clk), .reset(reset),
      .alu0_valid(alu0_valid), .alu0_ready(alu0_ready), .alu0_rd(alu0_rd),
      .alu0_data(alu0_data), .alu0_seq(alu0_seq),
      .alu1_valid(alu1_valid), .alu1_ready(alu1_ready), .alu1_rd(alu1_rd),
      .alu1_data(alu1_data), .alu1_seq(alu1_seq),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
      .mem_data(mem_data), .mem_seq(mem_seq),
      .write1(write1), .writeAddr_D1(writeAddr_D1), .writeData_D1(writeData_D1),
      .write2(write2), .writeAddr_D2(writeAddr_D2), .writeData_D2(writeData_D2),
      .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_src();
      alu0_valid = 0; alu0_rd = 0; alu0_data = 0; alu0_seq = 0;
      alu1_valid = 0; alu1_rd = 0; alu1_data = 0; alu1_seq = 0;
      mem_valid  = 0; mem_rd  = 0; mem_data  = 0; mem_seq  = 0;
   endtask

   task automatic drive(input int s, input logic [4:0] rd, input logic [31:0] d, input logic [3:0] sq);
      case (s)
         0: begin alu0_valid = 1; alu0_rd = rd; alu0_data = d; alu0_seq = sq; end
         1: begin alu1_valid = 1; alu1_rd = rd; alu1_data = d; alu1_seq = sq; end
         default: begin mem_valid = 1; mem_rd = rd; mem_data = d; mem_seq = sq; end
      endcase
   endtask

   task automatic chk_ports(input string tag, input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                            input logic w2, input logic [4:0] a2, input logic [31:0] d2, input logic [1:0] cnt);
      check({tag, ".write1"}, 64'(write1), 64'(w1));
      if (w1) begin
         check({tag, ".addr1"}, 64'(writeAddr_D1), 64'(a1));
         check({tag, ".data1"}, 64'(writeData_D1), 64'(d1));
      end
      check({tag, ".write2"}, 64'(write2), 64'(w2));
      if (w2) begin
         check({tag, ".addr2"}, 64'(writeAddr_D2), 64'(a2));
         check({tag, ".data2"}, 64'(writeData_D2), 64'(d2));
      end
      check({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(cnt));
   endtask

   task automatic rf_commit();
      if (write1) rf[writeAddr_D1] = writeData_D1;
      if (write2) rf[writeAddr_D2] = writeData_D2;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      clear_src();
      reset = 1;
      drive(0, 5'd1, 32'h1, 4'd0);
      drive(1, 5'd2, 32'h2, 4'd1);
      drive(2, 5'd3, 32'h3, 4'd2);
      repeat (2) begin
         @(negedge clk);
         check("rst.alu0_ready", 64'(alu0_ready), 64'd0);
         check("rst.alu1_ready", 64'(alu1_ready), 64'd0);
         check("rst.mem_ready",  64'(mem_ready),  64'd0);
         chk_ports("rst", 0, 0, 0, 0, 0, 0, 2'd0);
      end
      tick();
      reset = 0;
      clear_src();
      @(negedge clk);
      check("post_rst.alu0_ready", 64'(alu0_ready), 64'd1);
      check("post_rst.alu1_ready", 64'(alu1_ready), 64'd1);
      check("post_rst.mem_ready",  64'(mem_ready),  64'd1);

      // single result, then idle port keeps its address
      tick();
      drive(0, 5'd5, 32'hDEADBEEF, 4'd3);
      tick();
      clear_src();
      @(negedge clk);
      check("single.alu0_ready", 64'(alu0_ready), 64'd1);
      tick();
      chk_ports("single", 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 2'd1);
      tick();
      chk_ports("single_idle", 0, 0, 0, 0, 0, 0, 2'd0);
      check("single_idle.addr1_hold", 64'(writeAddr_D1), 64'd5);
      check("single_idle.data1_hold", 64'(writeData_D1), 64'hDEADBEEF);

      // three concurrent: alu1(5) oldest, mem(6), alu0(7) waits
      drive(0, 5'd1, 32'hA0, 4'd7);
      drive(1, 5'd2, 32'hB1, 4'd5);
      drive(2, 5'd3, 32'hC2, 4'd6);
      tick();
      clear_src();
      @(negedge clk);
      check("three.alu0_ready", 64'(alu0_ready), 64'd0);
      check("three.alu1_ready", 64'(alu1_ready), 64'd1);
      check("three.mem_ready",  64'(mem_ready),  64'd1);
      tick();
      chk_ports("three_n1", 1, 5'd2, 32'hB1, 1, 5'd3, 32'hC2, 2'd2);
      tick();
      chk_ports("three_n2", 1, 5'd1, 32'hA0, 0, 0, 0, 2'd1);

      // wrap-around: 15 is older than 0
      drive(0, 5'd4, 32'h15, 4'd15);
      drive(1, 5'd6, 32'h00, 4'd0);
      tick();
      clear_src();
      tick();
      chk_ports("wrap", 1, 5'd4, 32'h15, 1, 5'd6, 32'h00, 2'd2);

      // same rd: older on D1, younger on D2, D2 wins in the register file
      drive(1, 5'd9, 32'h11, 4'd2);
      drive(2, 5'd9, 32'h22, 4'd3);
      tick();
      clear_src();
      tick();
      chk_ports("same_rd", 1, 5'd9, 32'h11, 1, 5'd9, 32'h22, 2'd2);
      rf_commit();
      check("same_rd.rf9", 64'(rf[9]), 64'h22);

      // rd 0 is consumed without a write
      drive(2, 5'd0, 32'hBAD, 4'd4);
      @(negedge clk);
      check("rd0.mem_ready_in", 64'(mem_ready), 64'd1);
      tick();
      clear_src();
      @(negedge clk);
      check("rd0.mem_ready_after", 64'(mem_ready), 64'd1);
      tick();
      chk_ports("rd0", 0, 0, 0, 0, 0, 0, 2'd0);

      // hold three entries, reset discards them
      drive(0, 5'd10, 32'h100, 4'd8);
      drive(1, 5'd11, 32'h101, 4'd9);
      drive(2, 5'd12, 32'h102, 4'd10);
      tick();
      clear_src();
      reset = 1;
      @(negedge clk);
      check("midrst.alu0_ready", 64'(alu0_ready), 64'd0);
      tick();
      reset = 0;
      for (int c = 0; c < 4; c++) begin
         check("midrst.write1", 64'(write1), 64'd0);
         check("midrst.write2", 64'(write2), 64'd0);
         tick();
      end

      // stage still works after the mid-op reset
      drive(1, 5'd7, 32'h77, 4'd1);
      tick();
      clear_src();
      tick();
      chk_ports("after_rst", 1, 5'd7, 32'h77, 0, 0, 0, 2'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_merge.md
Name: wb_merge

Overview:
- Writeback merge stage for the dual-issue core.
- Accepts results from three producers (ALU0, ALU1, MEM) over valid/ready handshakes and holds each in a one-entry buffer.
- Each cycle, retires up to two buffered results, oldest first, onto the register file's two write ports (D1, D2).
- Guarantees architectural ordering on same-register conflicts: older result on D1, younger on D2, so the register file's D2-priority rule yields the correct final value.

Parameters:
- FILESIZE, 32, number of architectural registers; localparam REGADDR = $clog2(FILESIZE).
- REGSIZE, 32, data width of each register.
- SEQW, 4, width of the program-order sequence tag carried with every result.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- alu0_valid / alu1_valid / mem_valid  in  1  producer has a result.
- alu0_ready / alu1_ready / mem_ready  out  1  stage accepts that producer's result this cycle.
- alu0_rd / alu1_rd / mem_rd  in  REGADDR  destination register.
- alu0_data / alu1_data / mem_data  in  REGSIZE  result value.
- alu0_seq / alu1_seq / mem_seq  in  SEQW  program-order tag, wrapping.
- write1  out  1  port D1 write enable, registered.
- writeAddr_D1  out  REGADDR  port D1 address, registered.
- writeData_D1  out  REGSIZE  port D1 data, registered.
- write2  out  1  port D2 write enable, registered.
- writeAddr_D2  out  REGADDR  port D2 address, registered.
- writeData_D2  out  REGSIZE  port D2 data, registered.
- retire_cnt  out  2  results written this cycle (0..2); equals write1 + write2.

Behaviour:
- Reset (synchronous, active-high):
  - All holding-entry valid bits cleared.
  - write1, write2, both addresses, both data outputs and retire_cnt all zero.
  - All *_ready are 0 while reset is asserted.
  - Reset mid-operation discards held results with no write.
- Holding entries: one per source, each holding {valid, rd, data, seq}.
- Ready: src_ready = !held_valid | granted_this_cycle. This is combinational from the grant logic; there is no dependence on src_valid.
- Accept: on posedge with src_valid & src_ready:
  - rd != 0: entry loads the result.
  - rd == 0: result is consumed and dropped (never written, never held).
  - Entry not reloaded: if granted, its valid clears.
- Age compare (wrap-safe): a is older than b iff MSB of (a - b) mod 2^SEQW is 1.
  - Producers guarantee that in-flight tags span fewer than 2^(SEQW-1).
  - Equal tags never occur among valid entries.
- Grant, each cycle, among valid held entries:
  - Select the oldest and the second oldest.
  - Oldest goes to D1, second to D2.
  - One valid entry: it goes to D1 and D2 is idle.
  - Zero valid entries: no grant.
  - The third entry waits and keeps its contents.
- Output register:
  - On posedge, write1/writeAddr_D1/writeData_D1 and write2/writeAddr_D2/writeData_D2 load the grant; retire_cnt loads the number of grants.
  - Address and data of an idle port hold their previous values; only the enable drops.
- Latency: a result accepted at edge N is visible in its entry during cycle N and, if granted, drives write strobes during cycle N+1. The register file commits on the negedge of N+1. Minimum latency is 1 cycle.
- Same-rd conflict: two grants to the same rd both assert, older on D1, younger on D2. The register file keeps D2.
- Throughput: sustained 2 results/cycle. With three sources valid every cycle, each source is starved at most 1 cycle consecutively, because age ordering ages the waiting entry.
- No forwarding, no bypass from input to outputs, and no combinational path from src_valid to the write ports.

Test Plan:
- Reset: drive reset for 2 cycles with all valids high -> all *_ready=0, write1=write2=0, retire_cnt=0. First cycle after reset -> all ready=1.
- Single result: alu0 rd=5, data=0xDEADBEEF, seq=3 -> next cycle write1=1, writeAddr_D1=5, writeData_D1=0xDEADBEEF, write2=0, retire_cnt=1.
- Three concurrent results: seq alu0=7, alu1=5, mem=6 -> cycle N+1: D1=alu1, D2=mem. Cycle N+2: D1=alu0, write2=0. alu0_ready=0 during the first wait cycle, mem_ready=1.
- Wrap-around age: alu0 seq=15, alu1 seq=0 (SEQW=4) -> D1=alu0 (older), D2=alu1.
- Same-rd ordering: alu1 rd=9, data=0x11, seq=2; mem rd=9, data=0x22, seq=3 -> writeAddr_D1=writeAddr_D2=9, D1 data=0x11, D2 data=0x22. Register 9 reads 0x22 afterwards.
- rd=0 drop and mid-op reset:
  - mem rd=0 -> mem_ready=1, no write, retire_cnt=0.
  - Then hold 3 entries and assert reset for one cycle -> no writes ever issued for the discarded entries.
